adc7476a_axil_regs: RTL and testbench

AXI4-Lite slave register bank for the AD7476A ADC controller. It is the responder end of the S00_AXI bus that the VIP master drives. It decodes single-beat AXI4-Lite reads and writes into four 32-bit registers. It drives the control outputs (enable, continuous mode, SCLK divider) to the sampling engine and captures 12-bit samples returned from it.

---
 rtl/adc7476a_axil_regs_pkg.sv | 39 +++
 rtl/adc7476a_axil_regs_if.sv | 42 ++++
 rtl/adc7476a_axil_regs_axil_slave_if.sv | 110 +++++++++++
 rtl/adc7476a_axil_regs.sv | 135 +++++++++++++
 tb/tb_adc7476a_axil_regs.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc7476a_axil_regs_pkg.sv
// Register map constants, CTRL field layout and byte-strobe merge helper
// shared by the AD7476A AXI4-Lite register bank.
package adc7476a_regs_pkg;

    // Byte offsets of the four registers (decoded from addr[3:2])
    localparam logic [3:0] ADDR_CTRL    = 4'h0;
    localparam logic [3:0] ADDR_DIV     = 4'h4;
    localparam logic [3:0] ADDR_SAMPLE  = 4'h8;
    localparam logic [3:0] ADDR_SCRATCH = 4'hC;

    // CTRL bit positions
    localparam int unsigned CTRL_ENABLE_BIT  = 0;
    localparam int unsigned CTRL_CONT_BIT    = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT  = 2;
    localparam int unsigned CTRL_OVERRUN_BIT = 30;
    localparam int unsigned CTRL_READY_BIT   = 31;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Writable CTRL bits [2:0], MSB first
    typedef struct packed {
        logic irq_en;
        logic continuous;
        logic enable;
    } ctrl_t;

    // Merge new write data into an old value, one byte lane per strobe bit
    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) merged[i*8 +: 8] = new_v[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/adc7476a_axil_regs_if.sv
// AXI4-Lite bus bundle (S00_AXI) with master and slave views.
interface adc7476a_axil_regs_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, input S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, input S_AXI_WREADY,
        input S_AXI_BRESP, S_AXI_BVALID, output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, input S_AXI_ARREADY,
        input S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, output S_AXI_RREADY
    );

    modport slave (
        input S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, output S_AXI_AWREADY,
        input S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID, input S_AXI_BREADY,
        input S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, input S_AXI_RREADY
    );

endinterface

// File: rtl/adc7476a_axil_regs_axil_slave_if.sv
// AXI4-Lite slave handshake engine: holds AW and W independently, issues a
// single-cycle register write strobe once both are present, and turns AR
// into a one-cycle read request whose data is registered onto R.
module axil_slave_if
    import adc7476a_regs_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    adc7476a_axil_regs_if.slave s_axi,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W/8-1:0] wr_strb,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   rd_data,
    output logic                rd_done,
    output logic [ADDR_W-1:0]   rd_done_addr
);

    logic                aw_held;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic                w_held;
    logic [DATA_W-1:0]   w_data_q;
    logic [DATA_W/8-1:0] w_strb_q;
    logic                bvalid_q;
    logic                rvalid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [ADDR_W-1:0]   r_addr_q;

    logic awready, wready, arready;
    logic aw_hs, w_hs;
    logic unused_prot;

    assign unused_prot = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

    // Ready/handshake decode; readies are held low while in reset
    always_comb begin
        awready = ARESETN && !aw_held && !bvalid_q;
        wready  = ARESETN && !w_held  && !bvalid_q;
        arready = ARESETN && !rvalid_q;
        aw_hs   = s_axi.S_AXI_AWVALID && awready;
        w_hs    = s_axi.S_AXI_WVALID  && wready;
        wr_en   = (aw_held || aw_hs) && (w_held || w_hs);
        wr_addr = aw_held ? aw_addr_q : s_axi.S_AXI_AWADDR;
        wr_data = w_held  ? w_data_q  : s_axi.S_AXI_WDATA;
        wr_strb = w_held  ? w_strb_q  : s_axi.S_AXI_WSTRB;
        rd_en   = s_axi.S_AXI_ARVALID && arready;
        rd_addr = s_axi.S_AXI_ARADDR;
        rd_done = rvalid_q && s_axi.S_AXI_RREADY;
        rd_done_addr = r_addr_q;
    end

    assign s_axi.S_AXI_AWREADY = awready;
    assign s_axi.S_AXI_WREADY  = wready;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = RESP_OKAY;
    assign s_axi.S_AXI_ARREADY = arready;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = RESP_OKAY;

    // Write channel: AW/W holding registers and the B response
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held   <= 1'b0;
            aw_addr_q <= '0;
            w_held    <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
        end else begin
            if (bvalid_q && s_axi.S_AXI_BREADY) bvalid_q <= 1'b0;
            if (wr_en) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= s_axi.S_AXI_AWADDR;
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= s_axi.S_AXI_WDATA;
                    w_strb_q <= s_axi.S_AXI_WSTRB;
                end
            end
        end
    end

    // Read channel: register read data on AR handshake, hold until R handshake
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            r_addr_q <= '0;
        end else if (rd_en) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data;
            r_addr_q <= s_axi.S_AXI_ARADDR;
        end else if (rd_done) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/adc7476a_axil_regs.sv
// AD7476A controller register bank: CTRL/DIV/SAMPLE/SCRATCH behind an
// AXI4-Lite slave, plus sample capture with ready/overrun tracking.
module adc7476a_axil_regs
    import adc7476a_regs_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [15:0] DIV_RESET          = 16'd4
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    adc7476a_axil_regs_if.slave s00_axi,
    output logic                adc_enable,
    output logic                adc_continuous,
    output logic [15:0]         adc_clk_div,
    input  logic [11:0]         sample_data,
    input  logic                sample_valid,
    output logic                irq
);

    logic                            wr_en;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   wr_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb;
    logic                            rd_en;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   rd_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rd_data;
    logic                            rd_done;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   rd_done_addr;

    ctrl_t       ctrl_q;
    logic [15:0] div_q;
    logic [11:0] sample_q;
    logic [31:0] scratch_q;
    logic        sample_ready;
    logic        overrun;

    logic [3:0]  wr_sel, rd_sel, done_sel;
    logic [31:0] ctrl_wr, div_wr, scratch_wr;
    logic        sample_clr, overrun_set, overrun_clr;
    logic        unused_rd_en;
    logic        unused_addr_lsbs;

    axil_slave_if #(
        .ADDR_W(C_S_AXI_ADDR_WIDTH),
        .DATA_W(C_S_AXI_DATA_WIDTH)
    ) u_axil (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .s_axi        (s00_axi),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_strb      (wr_strb),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_done      (rd_done),
        .rd_done_addr (rd_done_addr)
    );

    assign unused_rd_en     = rd_en;
    assign unused_addr_lsbs = ^{wr_addr[1:0], rd_addr[1:0], rd_done_addr[1:0]};

    // Register select and byte-strobe merged write values
    always_comb begin
        wr_sel      = {wr_addr[3:2], 2'b00};
        rd_sel      = {rd_addr[3:2], 2'b00};
        done_sel    = {rd_done_addr[3:2], 2'b00};
        ctrl_wr     = apply_strb({29'd0, ctrl_q}, wr_data, wr_strb);
        div_wr      = apply_strb({16'd0, div_q}, wr_data, wr_strb);
        scratch_wr  = apply_strb(scratch_q, wr_data, wr_strb);
        sample_clr  = rd_done && (done_sel == ADDR_SAMPLE);
        overrun_set = sample_valid && sample_ready && !sample_clr;
        overrun_clr = wr_en && (wr_sel == ADDR_CTRL) && wr_strb[3]
                      && wr_data[CTRL_OVERRUN_BIT];
    end

    // Read mux over current register contents (old value on same-cycle write)
    always_comb begin
        rd_data = '0;
        case (rd_sel)
            ADDR_CTRL: begin
                rd_data[2:0]             = ctrl_q;
                rd_data[CTRL_OVERRUN_BIT] = overrun;
                rd_data[CTRL_READY_BIT]   = sample_ready;
            end
            ADDR_DIV:     rd_data[15:0] = div_q;
            ADDR_SAMPLE:  rd_data[11:0] = sample_q;
            ADDR_SCRATCH: rd_data       = scratch_q;
            default:      rd_data       = '0;
        endcase
    end

    // RW register file; SAMPLE writes are accepted and discarded
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ctrl_q    <= '0;
            div_q     <= DIV_RESET;
            scratch_q <= '0;
        end else if (wr_en) begin
            case (wr_sel)
                ADDR_CTRL:    ctrl_q    <= ctrl_t'(ctrl_wr[2:0]);
                ADDR_DIV:     div_q     <= div_wr[15:0];
                ADDR_SCRATCH: scratch_q <= scratch_wr;
                default:      ;
            endcase
        end
    end

    // Sample capture; a new sample beats a same-cycle read clear and a
    // new overrun beats a same-cycle W1C
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sample_q     <= '0;
            sample_ready <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (sample_valid) begin
                sample_q     <= sample_data;
                sample_ready <= 1'b1;
            end else if (sample_clr) begin
                sample_ready <= 1'b0;
            end
            if (overrun_set)      overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;
        end
    end

    assign adc_enable     = ctrl_q.enable;
    assign adc_continuous = ctrl_q.continuous;
    assign adc_clk_div    = div_q;
    assign irq            = ctrl_q.irq_en && sample_ready;

endmodule

// File: tb/tb_adc7476a_axil_regs.sv
// Directed self-checking bench for the AD7476A AXI4-Lite register bank.
`timescale 1ns/1ps
module tb_adc7476a_axil_regs;

    logic        ACLK;
    logic        ARESETN;
    logic        adc_enable;
    logic        adc_continuous;
    logic [15:0] adc_clk_div;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic        irq;

    int unsigned errors = 0;
    int unsigned checks = 0;

    adc7476a_axil_regs_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    adc7476a_axil_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4),
        .DIV_RESET(16'd4)
    ) dut (
        .ACLK           (ACLK),
        .ARESETN        (ARESETN),
        .s00_axi        (bus),
        .adc_enable     (adc_enable),
        .adc_continuous (adc_continuous),
        .adc_clk_div    (adc_clk_div),
        .sample_data    (sample_data),
        .sample_valid   (sample_valid),
        .irq            (irq)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        logic aw_pend, w_pend, aw_go, w_go;
        int unsigned n;
        bus.S_AXI_AWADDR = a; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_BREADY = 1'b1;
        aw_pend = 1'b1; w_pend = 1'b1; n = 0;
        while ((aw_pend || w_pend) && n < 20) begin
            aw_go = aw_pend && bus.S_AXI_AWREADY;
            w_go  = w_pend && bus.S_AXI_WREADY;
            tick();
            if (aw_go) begin bus.S_AXI_AWVALID = 1'b0; aw_pend = 1'b0; end
            if (w_go)  begin bus.S_AXI_WVALID  = 1'b0; w_pend  = 1'b0; end
            n++;
        end
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        n = 0;
        while (bus.S_AXI_BVALID !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b00) begin
            errors++;
            $display("FAIL write_resp addr=%h: bvalid=%b bresp=%b, required bvalid=1 bresp=00",
                     a, bus.S_AXI_BVALID, bus.S_AXI_BRESP);
        end
        tick();
        bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
        int unsigned n;
        bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b1;
        n = 0;
        while (bus.S_AXI_ARREADY !== 1'b1 && n < 20) begin tick(); n++; end
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        n = 0;
        while (bus.S_AXI_RVALID !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if (bus.S_AXI_RVALID !== 1'b1) begin
            errors++;
            $display("FAIL read_timeout addr=%h: rvalid=%b, required 1", a, bus.S_AXI_RVALID);
        end
        d = bus.S_AXI_RDATA; r = bus.S_AXI_RRESP;
        tick();
        bus.S_AXI_RREADY = 1'b0;
    endtask

    task automatic pulse_sample(input logic [11:0] v);
        sample_data = v; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        #12;
        checks++; if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b, required 000", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}); end
        checks++; if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b, required 00", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}); end
        checks++; if (bus.S_AXI_RDATA !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h, required 00000000", bus.S_AXI_RDATA); end
        checks++; if ({bus.S_AXI_BRESP, bus.S_AXI_RRESP} !== 4'b0000) begin errors++; $display("FAIL reset_resp: got %b, required 0000", {bus.S_AXI_BRESP, bus.S_AXI_RRESP}); end
        checks++; if (adc_clk_div !== 16'h0004) begin errors++; $display("FAIL reset_div: got %h, required 0004", adc_clk_div); end
        checks++; if ({adc_enable, adc_continuous, irq} !== 3'b000) begin errors++; $display("FAIL reset_ctrl_out: got %b, required 000", {adc_enable, adc_continuous, irq}); end
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        tick();
        checks++; if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin errors++; $display("FAIL idle_ready: got %b, required 111", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}); end
    endtask

    task automatic test_reg_rw();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(4'h0, 32'h1, 4'hF);
        axi_write(4'h4, 32'h2, 4'hF);
        axi_write(4'h8, 32'h3, 4'hF);
        axi_write(4'hC, 32'h4, 4'hF);
        axi_read(4'h0, d, r);
        checks++; if (d !== 32'h1 || r !== 2'b00) begin errors++; $display("FAIL rw_ctrl: got %h/%b, required 00000001/00", d, r); end
        axi_read(4'h4, d, r);
        checks++; if (d !== 32'h2 || r !== 2'b00) begin errors++; $display("FAIL rw_div: got %h/%b, required 00000002/00", d, r); end
        axi_read(4'h8, d, r);
        checks++; if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL rw_sample_ro: got %h/%b, required 00000000/00", d, r); end
        axi_read(4'hC, d, r);
        checks++; if (d !== 32'h4 || r !== 2'b00) begin errors++; $display("FAIL rw_scratch: got %h/%b, required 00000004/00", d, r); end
        checks++; if (adc_enable !== 1'b1 || adc_continuous !== 1'b0) begin errors++; $display("FAIL rw_enable_out: got %b%b, required en=1 cont=0", adc_enable, adc_continuous); end
        checks++; if (adc_clk_div !== 16'h0002) begin errors++; $display("FAIL rw_div_out: got %h, required 0002", adc_clk_div); end
    endtask

    task automatic test_split_write();
        logic [31:0] d;
        logic [1:0]  r;
        // AW three cycles ahead of W, BREADY low
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_AWADDR = 4'hC; bus.S_AXI_AWVALID = 1'b1;
        checks++; if (bus.S_AXI_AWREADY !== 1'b1) begin errors++; $display("FAIL split_aw_ready: got %b, required 1", bus.S_AXI_AWREADY); end
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        tick(); tick();
        checks++; if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID} !== 3'b010) begin errors++; $display("FAIL split_aw_held: got aw/w/b=%b, required 010", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID}); end
        bus.S_AXI_WDATA = 32'h1111_2222; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_WVALID = 1'b0;
        checks++; if (bus.S_AXI_BVALID !== 1'b1) begin errors++; $display("FAIL split_b_latency: got %b, required 1", bus.S_AXI_BVALID); end
        // A second address offered while the response is pending must wait
        bus.S_AXI_AWADDR = 4'h0; bus.S_AXI_AWVALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 3'b100) begin errors++; $display("FAIL split_b_hold cycle %0d: got b/aw/w=%b, required 100", i, {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}); end
            tick();
        end
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
        checks++; if (bus.S_AXI_BVALID !== 1'b0) begin errors++; $display("FAIL split_b_release: got %b, required 0", bus.S_AXI_BVALID); end
        tick(); tick();
        checks++; if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY} !== 2'b01) begin errors++; $display("FAIL split_single_resp: got b/aw=%b, required 01", {bus.S_AXI_BVALID, bus.S_AXI_AWREADY}); end
        // W two cycles ahead of AW
        bus.S_AXI_WDATA = 32'h0000_0009; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_WVALID = 1'b0;
        tick();
        checks++; if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID} !== 3'b100) begin errors++; $display("FAIL split_w_held: got aw/w/b=%b, required 100", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID}); end
        bus.S_AXI_AWADDR = 4'h4; bus.S_AXI_AWVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        tick(); tick();
        checks++; if (bus.S_AXI_BVALID !== 1'b1) begin errors++; $display("FAIL split_w_first_hold: got %b, required 1", bus.S_AXI_BVALID); end
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
        checks++; if (bus.S_AXI_BVALID !== 1'b0) begin errors++; $display("FAIL split_w_first_release: got %b, required 0", bus.S_AXI_BVALID); end
        axi_read(4'hC, d, r);
        checks++; if (d !== 32'h1111_2222) begin errors++; $display("FAIL split_scratch: got %h, required 11112222", d); end
        axi_read(4'h4, d, r);
        checks++; if (d !== 32'h9 || adc_clk_div !== 16'h0009) begin errors++; $display("FAIL split_div: got %h/%h, required 00000009/0009", d, adc_clk_div); end
        axi_read(4'h0, d, r);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL split_ctrl_untouched: got %h, required 00000001", d); end
    endtask

    task automatic test_strobe();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(4'hC, 32'hFFFF_FFFF, 4'hF);
        axi_write(4'hC, 32'hA5A5_A5A5, 4'b0101);
        axi_read(4'hC, d, r);
        checks++; if (d !== 32'hFFA5_FFA5) begin errors++; $display("FAIL strobe_scratch: got %h, required ffa5ffa5", d); end
        axi_write(4'h4, 32'hBEEF_1234, 4'b1110);
        axi_read(4'h4, d, r);
        checks++; if (d !== 32'h0000_1209) begin errors++; $display("FAIL strobe_div: got %h, required 00001209", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [1:0]  r;
        bus.S_AXI_AWADDR = 4'hC; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h1234_5678; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_ARADDR = 4'hC; bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
        checks++; if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin errors++; $display("FAIL b2b_ready: got %b, required 111", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}); end
        tick();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        checks++; if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 2'b11) begin errors++; $display("FAIL b2b_latency: got b/r=%b, required 11", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}); end
        checks++; if (bus.S_AXI_RDATA !== 32'hFFA5_FFA5) begin errors++; $display("FAIL b2b_old_value: got %h, required ffa5ffa5", bus.S_AXI_RDATA); end
        tick();
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
        axi_read(4'hC, d, r);
        checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL b2b_new_value: got %h, required 12345678", d); end
    endtask

    task automatic test_sample();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(4'h0, 32'h0, 4'hF);
        pulse_sample(12'hABC);
        pulse_sample(12'h123);
        axi_read(4'h0, d, r);
        checks++; if (d !== 32'hC000_0000) begin errors++; $display("FAIL sample_ctrl_flags: got %h, required c0000000", d); end
        axi_read(4'h8, d, r);
        checks++; if (d !== 32'h0000_0123) begin errors++; $display("FAIL sample_value: got %h, required 00000123", d); end
        axi_read(4'h0, d, r);
        checks++; if (d !== 32'h4000_0000) begin errors++; $display("FAIL sample_ready_cleared: got %h, required 40000000", d); end
        axi_write(4'h0, 32'h4000_0000, 4'b0111);
        axi_read(4'h0, d, r);
        checks++; if (d !== 32'h4000_0000) begin errors++; $display("FAIL w1c_no_strobe: got %h, required 40000000", d); end
        axi_write(4'h0, 32'h4000_0000, 4'hF);
        axi_read(4'h0, d, r);
        checks++; if (d !== 32'h0 || adc_enable !== 1'b0) begin errors++; $display("FAIL w1c_overrun: got %h en=%b, required 00000000 en=0", d, adc_enable); end
    endtask

    task automatic test_irq_same_cycle();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(4'h0, 32'h4, 4'hF);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b, required 0", irq); end
        pulse_sample(12'h055);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b, required 1", irq); end
        bus.S_AXI_ARADDR = 4'h8; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b0;
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        checks++; if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== 32'h055) begin errors++; $display("FAIL irq_read_data: got %b/%h, required 1/00000055", bus.S_AXI_RVALID, bus.S_AXI_RDATA); end
        bus.S_AXI_RREADY = 1'b1; sample_data = 12'h0AA; sample_valid = 1'b1;
        tick();
        bus.S_AXI_RREADY = 1'b0; sample_valid = 1'b0;
        checks++; if (bus.S_AXI_RVALID !== 1'b0 || irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins: got rvalid=%b irq=%b, required 0/1", bus.S_AXI_RVALID, irq); end
        axi_read(4'h0, d, r);
        checks++; if (d !== 32'h8000_0004) begin errors++; $display("FAIL irq_ctrl_no_overrun: got %h, required 80000004", d); end
        axi_read(4'h8, d, r);
        checks++; if (d !== 32'h0AA || irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %h irq=%b, required 000000aa irq=0", d, irq); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_AWADDR = 4'h4; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h33; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        checks++; if (bus.S_AXI_BVALID !== 1'b1 || adc_clk_div !== 16'h0033) begin errors++; $display("FAIL rst_pre: got b=%b div=%h, required 1/0033", bus.S_AXI_BVALID, adc_clk_div); end
        #2;
        ARESETN = 1'b0;
        #1;
        checks++; if (bus.S_AXI_BVALID !== 1'b0 || adc_clk_div !== 16'h0004) begin errors++; $display("FAIL rst_async: got b=%b div=%h, required 0/0004", bus.S_AXI_BVALID, adc_clk_div); end
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        bus.S_AXI_BREADY = 1'b1;
        tick(); tick(); tick();
        bus.S_AXI_BREADY = 1'b0;
        checks++; if (bus.S_AXI_BVALID !== 1'b0) begin errors++; $display("FAIL rst_no_resp: got %b, required 0", bus.S_AXI_BVALID); end
        axi_read(4'h4, d, r);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL rst_div_read: got %h, required 00000004", d); end
    endtask

    initial begin
        ARESETN = 1'b0;
        sample_data = '0; sample_valid = 1'b0;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        test_reset();
        test_reg_rw();
        test_split_write();
        test_strobe();
        test_back_to_back();
        test_sample();
        test_irq_same_cycle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
